wb_retire_q: RTL and testbench

WB_RETIRE_Q -- requirements
Module: wb_retire_q

---
 rtl/wb_retire_q.sv | 180 ++++++++++++++++++
 tb/tb_wb_retire_q.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_retire_q.sv
// Writeback retire queue.
// Holds up to DEPTH in-order entries from the memory stage and retires them one per cycle from the head.
// An exception or ertn at the head flushes the whole queue.
// With CSR_LAT=1, a CSR read at the head takes one extra wait cycle before it retires.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   ms2ws_valid/ms_*     incoming memory-stage entry; ws_allowin reports free space
//   csr_*                CSR read/write port, driven from the head entry
//   wb_ex, ertn_flush    exception / ertn retiring this cycle, with pc, vaddr, ecode, esubcode
//   ws_rf_*              register-file write-back; instret is the retired instruction count
//   debug_wb_*           copy of the write-back signals for trace comparison
module wb_retire_q #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CSR_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms2ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [31:0] ms_vaddr,
  input  logic [5:0]  ms_exc,
  input  logic        ms_ertn,
  input  logic        ms_rf_we,
  input  logic [4:0]  ms_rf_waddr,
  input  logic [31:0] ms_rf_wdata,
  input  logic        ms_csr_re,
  input  logic        ms_csr_we,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wmask,
  input  logic [31:0] ms_csr_wvalue,
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic        ws_rf_we,
  output logic [4:0]  ws_rf_waddr,
  output logic [31:0] ws_rf_wdata,
  output logic [63:0] instret,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic [5:0]  exc;
    logic        ertn;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
  } entry_t;

  typedef enum logic [0:0] {StRun, StCsrWait} state_e;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  state_e          state_q;
  logic [63:0]     instret_q;

  entry_t head, in_entry;
  logic   has_head, csr_stall, retire, flush, enq;

  always_comb begin
    in_entry            = '0;
    in_entry.pc         = ms_pc;
    in_entry.vaddr      = ms_vaddr;
    in_entry.exc        = ms_exc;
    in_entry.ertn       = ms_ertn;
    in_entry.rf_we      = ms_rf_we;
    in_entry.rf_waddr   = ms_rf_waddr;
    in_entry.rf_wdata   = ms_rf_wdata;
    in_entry.csr_re     = ms_csr_re;
    in_entry.csr_we     = ms_csr_we;
    in_entry.csr_num    = ms_csr_num;
    in_entry.csr_wmask  = ms_csr_wmask;
    in_entry.csr_wvalue = ms_csr_wvalue;
  end

  always_comb begin
    has_head   = (count_q != '0);
    // An empty queue presents an all-zero head, so every head-derived output reads 0.
    head       = has_head ? mem_q[head_q] : '0;
    csr_stall  = (CSR_LAT == 1) && (state_q == StRun) && head.csr_re && (head.exc == '0);
    retire     = has_head && !csr_stall;
    wb_ex      = retire && (head.exc != '0);
    ertn_flush = retire && head.ertn && !wb_ex;
    flush      = wb_ex | ertn_flush;
    ws_allowin = (count_q != CntW'(DEPTH));
    enq        = ms2ws_valid && ws_allowin && !flush;
  end

  always_comb begin
    wb_ecode = 6'h00;
    if (wb_ex) begin
      if (head.exc[5])      wb_ecode = 6'h00;
      else if (head.exc[4]) wb_ecode = 6'h08;
      else if (head.exc[3]) wb_ecode = 6'h0D;
      else if (head.exc[2]) wb_ecode = 6'h0B;
      else if (head.exc[1]) wb_ecode = 6'h0C;
      else                  wb_ecode = 6'h09;
    end
  end

  always_comb begin
    wb_esubcode       = 9'h000;
    csr_re            = head.csr_re;
    csr_num           = head.csr_num;
    csr_wmask         = head.csr_wmask;
    csr_wvalue        = head.csr_wvalue;
    csr_we            = retire && head.csr_we && !wb_ex;
    wb_pc             = head.pc;
    wb_vaddr          = head.vaddr;
    ws_rf_we          = retire && head.rf_we && !wb_ex && !ertn_flush;
    ws_rf_waddr       = head.rf_waddr;
    ws_rf_wdata       = head.csr_re ? csr_rvalue : head.rf_wdata;
    instret           = instret_q;
    debug_wb_pc       = head.pc;
    debug_wb_rf_we    = {4{ws_rf_we}};
    debug_wb_rf_wnum  = head.rf_waddr;
    debug_wb_rf_wdata = ws_rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= StRun;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= StRun;
    end else begin
      if (enq) begin
        mem_q[tail_q] <= in_entry;
        tail_q        <= tail_q + PtrW'(1);
      end
      if (retire) head_q <= head_q + PtrW'(1);
      case ({enq, retire})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (csr_stall)   state_q <= StCsrWait;
      else if (retire) state_q <= StRun;
    end
  end

  // ertn retires normally and counts; an excepting head does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire && !wb_ex) begin
      instret_q <= instret_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_wb_retire_q.sv
// Directed bench for wb_retire_q.
// Instance a: DEPTH=2, CSR_LAT=0. Instance b: DEPTH=4, CSR_LAT=1.
// Both instances share the same inputs.
module tb_wb_retire_q;

  logic clk, reset, ms2ws_valid, ms_ertn, ms_rf_we, ms_csr_re, ms_csr_we;
  logic [31:0] ms_pc, ms_vaddr, ms_rf_wdata, ms_csr_wmask, ms_csr_wvalue, csr_rvalue;
  logic [5:0]  ms_exc;
  logic [4:0]  ms_rf_waddr;
  logic [13:0] ms_csr_num;

  logic        a_allowin, a_csr_re, a_csr_we, a_wb_ex, a_ertn, a_rf_we;
  logic [13:0] a_csr_num;
  logic [31:0] a_csr_wmask, a_csr_wvalue, a_wb_pc, a_wb_vaddr, a_rf_wdata, a_dbg_pc, a_dbg_wdata;
  logic [5:0]  a_ecode;
  logic [8:0]  a_esub;
  logic [4:0]  a_rf_waddr, a_dbg_wnum;
  logic [3:0]  a_dbg_we;
  logic [63:0] a_instret;

  logic        b_allowin, b_csr_re, b_csr_we, b_wb_ex, b_ertn, b_rf_we;
  logic [13:0] b_csr_num;
  logic [31:0] b_csr_wmask, b_csr_wvalue, b_wb_pc, b_wb_vaddr, b_rf_wdata, b_dbg_pc, b_dbg_wdata;
  logic [5:0]  b_ecode;
  logic [8:0]  b_esub;
  logic [4:0]  b_rf_waddr, b_dbg_wnum;
  logic [3:0]  b_dbg_we;
  logic [63:0] b_instret;

  int vectors = 0;
  int miscompares = 0;

  wb_retire_q #(.DEPTH(2), .CSR_LAT(0)) u_a (
    .clk(clk), .reset(reset), .ms2ws_valid(ms2ws_valid), .ws_allowin(a_allowin),
    .ms_pc(ms_pc), .ms_vaddr(ms_vaddr), .ms_exc(ms_exc), .ms_ertn(ms_ertn),
    .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
    .csr_re(a_csr_re), .csr_num(a_csr_num), .csr_rvalue(csr_rvalue), .csr_we(a_csr_we),
    .csr_wmask(a_csr_wmask), .csr_wvalue(a_csr_wvalue), .wb_ex(a_wb_ex), .ertn_flush(a_ertn),
    .wb_pc(a_wb_pc), .wb_vaddr(a_wb_vaddr), .wb_ecode(a_ecode), .wb_esubcode(a_esub),
    .ws_rf_we(a_rf_we), .ws_rf_waddr(a_rf_waddr), .ws_rf_wdata(a_rf_wdata),
    .instret(a_instret), .debug_wb_pc(a_dbg_pc), .debug_wb_rf_we(a_dbg_we),
    .debug_wb_rf_wnum(a_dbg_wnum), .debug_wb_rf_wdata(a_dbg_wdata)
  );

  wb_retire_q #(.DEPTH(4), .CSR_LAT(1)) u_b (
    .clk(clk), .reset(reset), .ms2ws_valid(ms2ws_valid), .ws_allowin(b_allowin),
    .ms_pc(ms_pc), .ms_vaddr(ms_vaddr), .ms_exc(ms_exc), .ms_ertn(ms_ertn),
    .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
    .csr_re(b_csr_re), .csr_num(b_csr_num), .csr_rvalue(csr_rvalue), .csr_we(b_csr_we),
    .csr_wmask(b_csr_wmask), .csr_wvalue(b_csr_wvalue), .wb_ex(b_wb_ex), .ertn_flush(b_ertn),
    .wb_pc(b_wb_pc), .wb_vaddr(b_wb_vaddr), .wb_ecode(b_ecode), .wb_esubcode(b_esub),
    .ws_rf_we(b_rf_we), .ws_rf_waddr(b_rf_waddr), .ws_rf_wdata(b_rf_wdata),
    .instret(b_instret), .debug_wb_pc(b_dbg_pc), .debug_wb_rf_we(b_dbg_we),
    .debug_wb_rf_wnum(b_dbg_wnum), .debug_wb_rf_wdata(b_dbg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] pc, input logic [5:0] exc,
                     input logic ertn, input logic rfwe, input logic [4:0] wa,
                     input logic [31:0] wd, input logic cre, input logic cwe,
                     input logic [13:0] cnum);
    ms2ws_valid   = v;
    ms_pc         = pc;
    ms_vaddr      = pc ^ 32'h8000_0000;
    ms_exc        = exc;
    ms_ertn       = ertn;
    ms_rf_we      = rfwe;
    ms_rf_waddr   = wa;
    ms_rf_wdata   = wd;
    ms_csr_re     = cre;
    ms_csr_we     = cwe;
    ms_csr_num    = cnum;
    ms_csr_wmask  = 32'hFF00_FF00;
    ms_csr_wvalue = 32'h1234_5678;
  endtask

  // Excepting head on instance a; the entry offered alongside it must be dropped.
  task automatic exc_case(input logic [5:0] exc, input logic [5:0] code);
    put(1'b1, 32'h2000, exc, 1'b0, 1'b1, 5'd5, 32'h55, 1'b0, 1'b1, 14'h001);
    tick();
    put(1'b1, 32'h2100, 6'h00, 1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 14'h000);
    chk("exc_wb_ex", 64'(a_wb_ex), 64'd1);
    chk("exc_ecode", 64'(a_ecode), 64'(code));
    chk("exc_esub", 64'(a_esub), 64'd0);
    chk("exc_rf_we", 64'(a_rf_we), 64'd0);
    chk("exc_csr_we", 64'(a_csr_we), 64'd0);
    chk("exc_ertn", 64'(a_ertn), 64'd0);
    tick();
    ms2ws_valid = 1'b0;
    chk("exc_flushed_pc", 64'(a_wb_pc), 64'd0);
    chk("exc_flushed_ex", 64'(a_wb_ex), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    csr_rvalue = 32'h0;
    put(1'b0, 32'h0, 6'h00, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 14'h000);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_allowin_a", 64'(a_allowin), 64'd1);
    chk("rst_allowin_b", 64'(b_allowin), 64'd1);
    chk("rst_instret", a_instret, 64'd0);
    chk("rst_wb_pc", 64'(a_wb_pc), 64'd0);
    chk("rst_rf_we", 64'(a_rf_we), 64'd0);
    chk("rst_dbg_we", 64'(a_dbg_we), 64'd0);
    chk("rst_csr_re", 64'(b_csr_re), 64'd0);
    chk("rst_rf_wdata", 64'(a_rf_wdata), 64'd0);

    // Three back-to-back ALU writes.
    put(1'b1, 32'h1000, 6'h00, 1'b0, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 14'h000);
    tick();
    chk("alu1_rf_we", 64'(a_rf_we), 64'd1);
    chk("alu1_waddr", 64'(a_rf_waddr), 64'd1);
    chk("alu1_wdata", 64'(a_rf_wdata), 64'h11);
    chk("alu1_dbg_we", 64'(a_dbg_we), 64'hF);
    chk("alu1_pc", 64'(a_wb_pc), 64'h1000);
    chk("alu1_dbg_pc", 64'(a_dbg_pc), 64'h1000);
    chk("alu1_vaddr", 64'(a_wb_vaddr), 64'h8000_1000);
    chk("alu1_allowin", 64'(a_allowin), 64'd1);
    chk("alu1_instret", a_instret, 64'd0);
    put(1'b1, 32'h1004, 6'h00, 1'b0, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 14'h000);
    tick();
    chk("alu2_waddr", 64'(a_dbg_wnum), 64'd2);
    chk("alu2_wdata", 64'(a_dbg_wdata), 64'h22);
    chk("alu2_allowin", 64'(a_allowin), 64'd1);
    chk("alu2_instret", a_instret, 64'd1);
    put(1'b1, 32'h1008, 6'h00, 1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 14'h000);
    tick();
    chk("alu3_waddr", 64'(a_rf_waddr), 64'd3);
    chk("alu3_allowin", 64'(a_allowin), 64'd1);
    chk("alu3_instret", a_instret, 64'd2);
    ms2ws_valid = 1'b0;
    tick();
    chk("alu_done_instret", a_instret, 64'd3);
    chk("alu_done_instret_b", b_instret, 64'd3);
    chk("alu_done_rf_we", 64'(a_rf_we), 64'd0);
    chk("alu_done_pc", 64'(a_wb_pc), 64'd0);

    // Exception cause priority.
    exc_case(6'b100001, 6'h00);
    exc_case(6'b010000, 6'h08);
    exc_case(6'b001010, 6'h0D);
    exc_case(6'b000110, 6'h0B);
    exc_case(6'b000011, 6'h0C);
    exc_case(6'b000001, 6'h09);
    chk("exc_instret", a_instret, 64'd3);

    // Plain CSR write.
    put(1'b1, 32'h2200, 6'h00, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 14'h0C5);
    tick();
    ms2ws_valid = 1'b0;
    chk("csrw_we", 64'(a_csr_we), 64'd1);
    chk("csrw_num", 64'(a_csr_num), 64'h0C5);
    chk("csrw_mask", 64'(a_csr_wmask), 64'hFF00_FF00);
    chk("csrw_value", 64'(a_csr_wvalue), 64'h1234_5678);
    chk("csrw_rf_we", 64'(a_rf_we), 64'd0);
    tick();
    chk("csrw_instret", a_instret, 64'd4);

    // ertn at head with a new entry offered in the same cycle.
    put(1'b1, 32'h2300, 6'h00, 1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 14'h000);
    tick();
    put(1'b1, 32'h2400, 6'h00, 1'b0, 1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 14'h000);
    chk("ertn_flush", 64'(a_ertn), 64'd1);
    chk("ertn_flush_b", 64'(b_ertn), 64'd1);
    chk("ertn_wb_ex", 64'(a_wb_ex), 64'd0);
    chk("ertn_rf_we", 64'(a_rf_we), 64'd0);
    chk("ertn_instret", a_instret, 64'd4);
    tick();
    ms2ws_valid = 1'b0;
    chk("ertn_dropped_pc", 64'(a_wb_pc), 64'd0);
    chk("ertn_dropped_pc_b", 64'(b_wb_pc), 64'd0);
    chk("ertn_after", 64'(a_ertn), 64'd0);
    chk("ertn_allowin", 64'(a_allowin), 64'd1);
    chk("ertn_instret_after", a_instret, 64'd5);
    chk("ertn_instret_b", b_instret, 64'd5);

    // CSR read with one wait cycle on instance b.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_instret_a", a_instret, 64'd0);
    chk("rst2_instret_b", b_instret, 64'd0);
    csr_rvalue = 32'hA5;
    put(1'b1, 32'h3000, 6'h00, 1'b0, 1'b1, 5'd9, 32'hDEAD, 1'b1, 1'b0, 14'h000);
    tick();
    ms2ws_valid = 1'b0;
    chk("csrr_head_re", 64'(b_csr_re), 64'd1);
    chk("csrr_head_num", 64'(b_csr_num), 64'd0);
    chk("csrr_head_pc", 64'(b_wb_pc), 64'h3000);
    chk("csrr_wait_rf_we", 64'(b_rf_we), 64'd0);
    chk("csrr_lat0_rf_we", 64'(a_rf_we), 64'd1);
    chk("csrr_lat0_wdata", 64'(a_rf_wdata), 64'hA5);
    tick();
    chk("csrr_ret_rf_we", 64'(b_rf_we), 64'd1);
    chk("csrr_ret_wdata", 64'(b_rf_wdata), 64'hA5);
    chk("csrr_ret_dbg_wdata", 64'(b_dbg_wdata), 64'hA5);
    chk("csrr_ret_waddr", 64'(b_rf_waddr), 64'd9);
    chk("csrr_ret_instret", b_instret, 64'd0);
    tick();
    chk("csrr_done_rf_we", 64'(b_rf_we), 64'd0);
    chk("csrr_done_pc", 64'(b_wb_pc), 64'd0);
    chk("csrr_done_instret", b_instret, 64'd1);

    // Fill instance b: CSR reads enqueued every cycle, retiring every other cycle.
    // K6 is held until b accepts it.
    n = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i <= 6)
        put(1'b1, 32'h3100 + 32'(4 * (i - 1)), 6'h00, 1'b0, 1'b1, 5'(10 + i - 1),
            32'h0, 1'b1, 1'b0, 14'h000);
      else if (i <= 8)
        put(1'b1, 32'h3118, 6'h00, 1'b0, 1'b1, 5'd16, 32'h0, 1'b1, 1'b0, 14'h000);
      else
        ms2ws_valid = 1'b0;
      tick();
      if (b_rf_we) begin
        chk("fill_order_waddr", 64'(b_rf_waddr), 64'(10 + n));
        chk("fill_order_pc", 64'(b_wb_pc), 64'(32'h3100 + 32'(4 * n)));
        n++;
      end
      if (i == 6 || i == 8) chk("fill_full_allowin", 64'(b_allowin), 64'd0);
      if (i == 7) chk("fill_space_allowin", 64'(b_allowin), 64'd1);
    end
    chk("fill_retired", 64'(n), 64'd7);
    chk("fill_instret", b_instret, 64'd8);

    // Reset while instance b sits in the CSR wait state with three entries queued.
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 32'h3200 + 32'(4 * i), 6'h00, 1'b0, 1'b1, 5'(20 + i), 32'h0, 1'b1, 1'b0,
          14'h000);
      tick();
    end
    chk("prerst_wait_rf_we", 64'(b_rf_we), 64'd1);
    chk("prerst_wait_waddr", 64'(b_rf_waddr), 64'd21);
    reset = 1'b1;
    put(1'b1, 32'h3300, 6'h00, 1'b0, 1'b1, 5'd30, 32'h0, 1'b0, 1'b0, 14'h000);
    tick();
    reset = 1'b0;
    ms2ws_valid = 1'b0;
    chk("rst3_instret", b_instret, 64'd0);
    chk("rst3_allowin", 64'(b_allowin), 64'd1);
    chk("rst3_rf_we", 64'(b_rf_we), 64'd0);
    chk("rst3_pc", 64'(b_wb_pc), 64'd0);
    chk("rst3_csr_re", 64'(b_csr_re), 64'd0);
    chk("rst3_rf_wdata", 64'(b_rf_wdata), 64'd0);
    chk("rst3_dbg_we", 64'(b_dbg_we), 64'd0);
    chk("rst3_wb_ex", 64'(b_wb_ex), 64'd0);
    tick();
    chk("rst3_no_enq_pc", 64'(b_wb_pc), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
